// File: rtl/vector_frame_tx_if.sv
// Bundles the PC command, buffer-ready, buffer RAM read and UART transmitter signals
// of vector_frame_tx; master is the frame transmitter, slave is its environment.
interface vector_frame_tx_if #(
    parameter int ADDR_W = 14
);
    logic              cmd_valid;
    logic [7:0]        cmd_byte;
    logic              frame_ready;
    logic [ADDR_W-1:0] frame_len;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_rdata;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              active;
    logic              frame_done;
    logic              overrun;

    modport master (
        input  cmd_valid, cmd_byte, frame_ready, frame_len, ram_rdata, tx_busy,
        output ram_addr, tx_start, tx_data, active, frame_done, overrun
    );

    modport slave (
        output cmd_valid, cmd_byte, frame_ready, frame_len, ram_rdata, tx_busy,
        input  ram_addr, tx_start, tx_data, active, frame_done, overrun
    );
endinterface

// File: rtl/vector_frame_tx.sv
// Streams filled vector buffers byte-by-byte to a UART transmitter under PC START/STOP control.
// Define VECTOR_TX_HEADER_EN to prefix every frame with the header A5, len[7:0], len[15:8].
module vector_frame_tx #(
    parameter logic [7:0] START_CMD = 8'hAB,
    parameter logic [7:0] STOP_CMD  = 8'hCD,
    parameter int         ADDR_W    = 14
) (
    input  logic              clk,
    input  logic              rst,
    vector_frame_tx_if.master bus
);

`ifdef VECTOR_TX_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT_IDLE,
        START,
        NEXT
    } state_t;

    state_t            state_reg;
    logic              enable_reg;
    logic              pending_full_reg;
    logic [ADDR_W-1:0] pending_len_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [1:0]        hdr_left_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic              tx_start_reg;
    logic [7:0]        tx_data_reg;
    logic              frame_done_reg;
    logic              overrun_reg;

    logic              cmd_start;
    logic              cmd_stop;
    logic              consume;
    logic [ADDR_W-1:0] idx_next;
    logic [15:0]       len16;
    logic [7:0]        hdr_byte;

    assign cmd_start = bus.cmd_valid && (bus.cmd_byte == START_CMD);
    assign cmd_stop  = bus.cmd_valid && (bus.cmd_byte == STOP_CMD);
    assign consume   = (state_reg == IDLE) && pending_full_reg && enable_reg;
    assign idx_next  = idx_reg + ADDR_W'(1);

    // Header length field is always 16 bits wide regardless of ADDR_W.
    generate
        if (ADDR_W >= 16) begin : g_len_trunc
            assign len16 = len_reg[15:0];
        end else begin : g_len_pad
            assign len16 = {{(16-ADDR_W){1'b0}}, len_reg};
        end
    endgenerate

    // hdr_left counts header bytes still to send: 3 -> sync, 2 -> low, 1 -> high.
    always_comb begin
        hdr_byte = 8'hA5;
        case (hdr_left_reg)
            2'd2:    hdr_byte = len16[7:0];
            2'd1:    hdr_byte = len16[15:8];
            default: hdr_byte = 8'hA5;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            enable_reg       <= 1'b0;
            pending_full_reg <= 1'b0;
            pending_len_reg  <= '0;
            len_reg          <= '0;
            idx_reg          <= '0;
            hdr_left_reg     <= 2'd0;
            ram_addr_reg     <= '0;
            tx_start_reg     <= 1'b0;
            tx_data_reg      <= 8'h00;
            frame_done_reg   <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;

            if (cmd_start) begin
                enable_reg <= 1'b1;
            end else if (cmd_stop) begin
                enable_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (consume) begin
                        pending_full_reg <= 1'b0;
                        len_reg          <= pending_len_reg;
                        idx_reg          <= '0;
                        if (HDR_EN) begin
                            hdr_left_reg <= 2'd3;
                            ram_addr_reg <= '0;
                            state_reg    <= FETCH;
                        end else if (pending_len_reg == '0) begin
                            frame_done_reg <= 1'b1;
                        end else begin
                            ram_addr_reg <= '0;
                            state_reg    <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    state_reg <= enable_reg ? LOAD : IDLE;
                end

                LOAD: begin
                    if (!enable_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        tx_data_reg <= (hdr_left_reg != 2'd0) ? hdr_byte : bus.ram_rdata[7:0];
                        state_reg   <= WAIT_IDLE;
                    end
                end

                WAIT_IDLE: begin
                    if (!enable_reg) begin
                        state_reg <= IDLE;
                    end else if (!bus.tx_busy) begin
                        tx_start_reg <= 1'b1;
                        state_reg    <= START;
                    end
                end

                // A byte already requested always finishes its handshake, even after STOP.
                START: begin
                    if (bus.tx_busy) begin
                        tx_start_reg <= 1'b0;
                        state_reg    <= NEXT;
                    end
                end

                NEXT: begin
                    if (!enable_reg) begin
                        state_reg <= IDLE;
                    end else if (hdr_left_reg != 2'd0) begin
                        hdr_left_reg <= hdr_left_reg - 2'd1;
                        if ((hdr_left_reg == 2'd1) && (len_reg == '0)) begin
                            frame_done_reg <= 1'b1;
                            state_reg      <= IDLE;
                        end else begin
                            ram_addr_reg <= idx_reg;
                            state_reg    <= FETCH;
                        end
                    end else begin
                        idx_reg <= idx_next;
                        if (idx_next == len_reg) begin
                            frame_done_reg <= 1'b1;
                            state_reg      <= IDLE;
                        end else begin
                            ram_addr_reg <= idx_next;
                            state_reg    <= FETCH;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase

            // Pending slot: later assignments here override the consume above.
            if (cmd_stop) begin
                pending_full_reg <= 1'b0;
            end else if (bus.frame_ready && enable_reg) begin
                if (pending_full_reg && !consume) begin
                    overrun_reg <= 1'b1;
                end
                pending_full_reg <= 1'b1;
                pending_len_reg  <= bus.frame_len;
            end
        end
    end

    assign bus.ram_addr   = ram_addr_reg;
    assign bus.tx_start   = tx_start_reg & ~rst;
    assign bus.tx_data    = tx_data_reg;
    assign bus.active     = (state_reg != IDLE);
    assign bus.frame_done = frame_done_reg;
    assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_vector_frame_tx.sv
// Randomized bench for vector_frame_tx: a UART/RAM responder feeds the DUT and the sent
// bytes are compared with frame contents predicted from buffer data and frame lengths.
module tb_vector_frame_tx;
    localparam int ADDR_W = 14;
`ifdef VECTOR_TX_HEADER_EN
    localparam int HDR_N = 3;
`else
    localparam int HDR_N = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_frame_tx_if #(.ADDR_W(ADDR_W)) bus ();

    vector_frame_tx #(
        .START_CMD(8'hAB),
        .STOP_CMD (8'hCD),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] mem [0:255];
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];
    int busy_cnt  = 0;
    int busy_len  = 10;
    int done_cnt  = 0;
    int start_cyc = 0;
    int checks    = 0;
    int failures  = 0;

    // Buffer RAM with one-cycle registered read.
    always @(posedge clk) bus.ram_rdata <= mem[bus.ram_addr[7:0]];

    // UART responder: accepts a byte when idle and tx_start is seen, then stays busy.
    assign bus.tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (bus.tx_start) begin
            got_q.push_back(bus.tx_data);
            busy_cnt <= busy_len;
        end
    end

    always @(negedge clk) begin
        if (bus.frame_done) done_cnt = done_cnt + 1;
        if (bus.tx_start) start_cyc = start_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_byte    = 8'h00;
        bus.frame_ready = 1'b0;
        bus.frame_len   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        done_cnt  = 0;
        start_cyc = 0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = b;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic pulse_frame(input int len);
        @(negedge clk);
        bus.frame_ready = 1'b1;
        bus.frame_len   = ADDR_W'(len);
        @(negedge clk);
        bus.frame_ready = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    endtask

    // Reference: a frame is the optional header followed by the low bytes of mem[0..len-1].
    task automatic build_exp(input int len);
`ifdef VECTOR_TX_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(len & 32'hFF));
        exp_q.push_back(8'((len >> 8) & 32'h3F));
`endif
        for (int i = 0; i < len; i++) exp_q.push_back(8'(mem[i] & 16'h00FF));
    endtask

    task automatic compare_bytes(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_reached"}, 32'(done_cnt >= target), 1);
    endtask

    task automatic wait_bytes(input string tag, input int target, input int budget);
        int n = 0;
        while (got_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_bytes_reached"}, 32'(got_q.size() >= target), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_addr"},   32'(bus.ram_addr), 0);
        check({tag, "_tx_start"},   32'(bus.tx_start), 0);
        check({tag, "_tx_data"},    32'(bus.tx_data), 0);
        check({tag, "_active"},     32'(bus.active), 0);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
        check({tag, "_overrun"},    32'(bus.overrun), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int l1;
        int l2;
        bit hit;

        // Reset state, then the basic three-byte frame.
        fill_mem();
        do_reset();
        check_reset_outputs("reset");
        send_cmd(8'hAB);
        mem[0] = 16'(($urandom & 32'hFF00) | 11);
        mem[1] = 16'(($urandom & 32'hFF00) | 22);
        mem[2] = 16'(($urandom & 32'hFF00) | 33);
        busy_len = 10;
        build_exp(3);
        pulse_frame(3);
        wait_done("basic", 1, 1000);
        repeat (5) @(negedge clk);
        compare_bytes("basic");
        check("basic_done_count", done_cnt, 1);
        check("basic_active_low", 32'(bus.active), 0);

        // Random frames with random UART busy times.
        for (int f = 0; f < 5; f++) begin
            fill_mem();
            busy_len = $urandom_range(1, 12);
            len      = $urandom_range(1, 8);
            got_q.delete();
            exp_q.delete();
            done_cnt = 0;
            build_exp(len);
            pulse_frame(len);
            wait_done($sformatf("rand%0d", f), 1, 2000);
            repeat (3) @(negedge clk);
            compare_bytes($sformatf("rand%0d", f));
            check($sformatf("rand%0d_active_low", f), 32'(bus.active), 0);
        end
        check("rand_no_overrun", 32'(bus.overrun), 0);

        // Frames while disabled are ignored and not held over for a later START.
        do_reset();
        pulse_frame(5);
        repeat (50) @(negedge clk);
        check("disabled_tx_start_cycles", start_cyc, 0);
        check("disabled_overrun", 32'(bus.overrun), 0);
        send_cmd(8'hAB);
        repeat (30) @(negedge clk);
        check("disabled_then_start_bytes", got_q.size(), 0);
        check("disabled_then_start_done", done_cnt, 0);

        // STOP during the second buffer byte.
        do_reset();
        fill_mem();
        send_cmd(8'hAB);
        busy_len = 10;
        pulse_frame(4);
        wait_bytes("stop", HDR_N + 2, 1000);
        send_cmd(8'hCD);
        repeat (100) @(negedge clk);
        build_exp(4);
        while (exp_q.size() > HDR_N + 2) void'(exp_q.pop_back());
        compare_bytes("stop");
        check("stop_no_done", done_cnt, 0);
        check("stop_active_low", 32'(bus.active), 0);

        // Two frame_ready pulses during byte 1: overrun and newest length wins.
        do_reset();
        fill_mem();
        send_cmd(8'hAB);
        busy_len = 10;
        l1 = $urandom_range(1, 6);
        l2 = $urandom_range(1, 6);
        pulse_frame(2);
        wait_bytes("ovr", HDR_N + 1, 1000);
        pulse_frame(l1);
        pulse_frame(l2);
        wait_done("ovr", 2, 3000);
        repeat (60) @(negedge clk);
        build_exp(2);
        build_exp(l2);
        compare_bytes("ovr");
        check("ovr_flag", 32'(bus.overrun), 1);
        check("ovr_done_count", done_cnt, 2);

        // Zero-length frame.
        do_reset();
        send_cmd(8'hAB);
        busy_len = $urandom_range(1, 12);
        pulse_frame(0);
        hit = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.frame_done) hit = 1'b1;
        end
`ifdef VECTOR_TX_HEADER_EN
        wait_done("zero", 1, 500);
`else
        check("zero_done_within_2", 32'(hit), 1);
`endif
        repeat (20) @(negedge clk);
        build_exp(0);
        compare_bytes("zero");
        check("zero_done_count", done_cnt, 1);

        // Reset while tx_start is high, then a normal frame.
        do_reset();
        fill_mem();
        send_cmd(8'hAB);
        busy_len = 10;
        pulse_frame(3);
        begin
            int n = 0;
            while (!bus.tx_start && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_saw_tx_start", 32'(bus.tx_start), 1);
        rst = 1'b1;
        #1;
        check("rst_tx_start_drop", 32'(bus.tx_start), 0);
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        send_cmd(8'hAB);
        len = $urandom_range(1, 8);
        build_exp(len);
        pulse_frame(len);
        wait_done("after_rst", 1, 2000);
        repeat (3) @(negedge clk);
        compare_bytes("after_rst");
        check("after_rst_overrun", 32'(bus.overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
